mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: main-memory responder for the processor/memory bus.
//
// Accepts BUS_LOAD / BUS_STORE commands, grants the lowest free tag on
// mem2proc_response in the same cycle, and returns each load's data with
// its tag exactly LATENCY cycles after acceptance. Stores write the array
// at the end of the accepting cycle and never complete.
//
// Ports:
//   clock              rising-edge clock
//   reset              asynchronous, active-low reset
//   proc2mem_command   0=NONE, 1=LOAD, 2=STORE, 3=illegal (ignored)
//   proc2mem_addr      byte address; word index = addr[AW+2:3]
//   proc2mem_data      store data
//   mem2proc_response  tag granted this cycle, 0 = rejected/none
//   mem2proc_data      load data, valid when mem2proc_tag != 0
//   mem2proc_tag       tag of the load completing this cycle, 0 = none
module mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 10,
    parameter int NUM_TAGS  = 15,
    parameter int XLEN      = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);
    localparam int AW     = $clog2(MEM_WORDS);
    // Stage s holds a load accepted s cycles ago; the last stage feeds the
    // output register, giving completion LATENCY cycles after acceptance.
    localparam int STAGES = LATENCY - 1;

    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef struct packed {
        logic [3:0]    tag;
        logic [AW-1:0] idx;
    } ld_req_t;

    logic [63:0]           mem [MEM_WORDS];
    logic [NUM_TAGS:1]     busy;
    logic [3:0]            free_tag;
    logic [AW-1:0]         word_idx;
    logic                  ld_acc;
    logic                  st_acc;
    logic [STAGES:1]       vld_pipe;
    ld_req_t [STAGES:1]    req_pipe;
    logic                  unused_addr;

    assign word_idx    = proc2mem_addr[AW+2:3];
    // Byte-offset and upper bits are deliberately ignored (addresses wrap).
    assign unused_addr = ^proc2mem_addr;

    // Lowest-numbered free tag; descending scan so the smallest index wins.
    always_comb begin
        free_tag = '0;
        for (int t = NUM_TAGS; t >= 1; t--) begin
            if (!busy[t]) free_tag = 4'(t);
        end
    end

    always_comb begin
        mem2proc_response = '0;
        ld_acc            = 1'b0;
        st_acc            = 1'b0;
        if (reset && free_tag != '0) begin
            if (proc2mem_command == BUS_LOAD) begin
                mem2proc_response = free_tag;
                ld_acc            = 1'b1;
            end else if (proc2mem_command == BUS_STORE) begin
                mem2proc_response = free_tag;
                st_acc            = 1'b1;
            end
        end
    end

    // Backing store is not reset.
    always_ff @(posedge clock) begin
        if (st_acc) mem[word_idx] <= proc2mem_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy          <= '0;
            vld_pipe      <= '0;
            req_pipe      <= '0;
            mem2proc_tag  <= '0;
            mem2proc_data <= '0;
        end else begin
            vld_pipe[1] <= ld_acc;
            req_pipe[1] <= '{tag: free_tag, idx: word_idx};
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                req_pipe[s] <= req_pipe[s-1];
            end

            // Read uses the pre-edge array value, so a store landing on this
            // same edge is not visible in the returned data.
            if (vld_pipe[STAGES]) begin
                mem2proc_tag  <= req_pipe[STAGES].tag;
                mem2proc_data <= mem[req_pipe[STAGES].idx];
            end else begin
                mem2proc_tag  <= '0;
            end

            // A granted tag is free and a completing tag is busy, so the set
            // and clear never target the same tag in one cycle.
            for (int t = 1; t <= NUM_TAGS; t++) begin
                if (ld_acc && free_tag == 4'(t))
                    busy[t] <= 1'b1;
                else if (mem2proc_tag == 4'(t))
                    busy[t] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder. LATENCY is raised to 20 so that all
// 15 tags can be outstanding at once (full condition reachable).
module tb_mem_responder;
    localparam int LAT = 20;
    localparam logic [1:0] NONE = 2'd0, LD = 2'd1, ST = 2'd2, ILL = 2'd3;

    logic        clock;
    logic        reset;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [3:0]  resp;
    logic [63:0] rdata;
    logic [3:0]  rtag;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_responder #(
        .MEM_WORDS(1024), .LATENCY(LAT), .NUM_TAGS(15), .XLEN(32)
    ) dut (
        .clock(clock), .reset(reset),
        .proc2mem_command(cmd), .proc2mem_addr(addr), .proc2mem_data(wdata),
        .mem2proc_response(resp), .mem2proc_data(rdata), .mem2proc_tag(rtag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One bus cycle: drive at the falling edge, settle, caller then samples.
    task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
        @(negedge clock);
        cmd = c; addr = a; wdata = d;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; cmd = NONE; addr = '0; wdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd = NONE; addr = '0; wdata = '0;
        repeat (2) @(negedge clock);
        cmd = LD;
        #1;
        checks++; if (resp !== 4'd0) begin failures++; $display("FAIL reset_resp got=%0d exp=0", resp); end
        checks++; if (rtag !== 4'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", rtag); end
        checks++; if (rdata !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", rdata); end
        cmd = NONE;
    endtask

    task automatic test_store_load();
        logic [3:0] et;
        do_reset();
        step(ST, 32'h100, 64'hDEADBEEF_01234567);
        checks++; if (resp !== 4'd1) begin failures++; $display("FAIL sl_store_resp got=%0d exp=1", resp); end
        step(LD, 32'h100, 64'd0);
        checks++; if (resp !== 4'd1) begin failures++; $display("FAIL sl_load_resp got=%0d exp=1", resp); end
        for (int c = 3; c <= LAT + 4; c++) begin
            step(NONE, 32'd0, 64'd0);
            et = (c == LAT + 2) ? 4'd1 : 4'd0;
            checks++; if (rtag !== et) begin failures++; $display("FAIL sl_tag cyc=%0d got=%0d exp=%0d", c, rtag, et); end
            if (c == LAT + 2) begin
                checks++;
                if (rdata !== 64'hDEADBEEF_01234567) begin failures++; $display("FAIL sl_data got=%h exp=deadbeef01234567", rdata); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  er, et;
        logic [63:0] ed;
        do_reset();
        for (int i = 1; i <= 15; i++) step(ST, 32'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i));
        do_reset();  // memory survives reset
        for (int c = 1; c <= LAT + 16; c++) begin
            if (c <= 22) step(LD, (c <= 15) ? 32'(c * 8) : 32'd0, 64'd0);
            else         step(NONE, 32'd0, 64'd0);
            er = (c <= 15) ? 4'(c) : ((c == 22) ? 4'd1 : 4'd0);
            et = (c >= LAT + 1 && c <= LAT + 15) ? 4'(c - LAT) : 4'd0;
            checks++; if (resp !== er) begin failures++; $display("FAIL b2b_resp cyc=%0d got=%0d exp=%0d", c, resp, er); end
            checks++; if (rtag !== et) begin failures++; $display("FAIL b2b_tag cyc=%0d got=%0d exp=%0d", c, rtag, et); end
            if (et != 4'd0) begin
                ed = 64'hA5A5_0000_0000_0000 | 64'(et);
                checks++; if (rdata !== ed) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", c, rdata, ed); end
            end
        end
    endtask

    task automatic test_alias();
        do_reset();
        step(ST, 32'h8, 64'h1111_2222_3333_4444);
        step(ST, 32'h2008, 64'h5555_6666_7777_8888);
        checks++; if (resp !== 4'd1) begin failures++; $display("FAIL alias_store_resp got=%0d exp=1", resp); end
        step(LD, 32'hD, 64'd0);
        checks++; if (resp !== 4'd1) begin failures++; $display("FAIL alias_load_resp got=%0d exp=1", resp); end
        repeat (LAT) step(NONE, 32'd0, 64'd0);
        checks++; if (rtag !== 4'd1) begin failures++; $display("FAIL alias_tag got=%0d exp=1", rtag); end
        checks++; if (rdata !== 64'h5555_6666_7777_8888) begin failures++; $display("FAIL alias_data got=%h exp=5555666677778888", rdata); end
    endtask

    // Load accepted in cycle 2; store B lands either on the data-read edge
    // (late: old data A returned) or one cycle earlier (B returned).
    task automatic test_race(input bit late);
        logic [63:0] ed;
        int sc;
        do_reset();
        sc = late ? LAT + 1 : LAT;
        ed = late ? 64'hAAAA_AAAA_AAAA_AAAA : 64'hBBBB_BBBB_BBBB_BBBB;
        step(ST, 32'h40, 64'hAAAA_AAAA_AAAA_AAAA);
        step(LD, 32'h40, 64'd0);
        checks++; if (resp !== 4'd1) begin failures++; $display("FAIL race_load_resp late=%0d got=%0d exp=1", late, resp); end
        for (int c = 3; c <= LAT + 2; c++) begin
            if (c == sc) begin
                step(ST, 32'h40, 64'hBBBB_BBBB_BBBB_BBBB);
                checks++; if (resp !== 4'd2) begin failures++; $display("FAIL race_store_resp late=%0d got=%0d exp=2", late, resp); end
            end else begin
                step(NONE, 32'd0, 64'd0);
            end
        end
        checks++; if (rtag !== 4'd1) begin failures++; $display("FAIL race_tag late=%0d got=%0d exp=1", late, rtag); end
        checks++; if (rdata !== ed) begin failures++; $display("FAIL race_data late=%0d got=%h exp=%h", late, rdata, ed); end
    endtask

    task automatic test_illegal();
        do_reset();
        step(ST, 32'h80, 64'hC0C0_C0C0_C0C0_C0C0);
        step(ILL, 32'h80, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (resp !== 4'd0) begin failures++; $display("FAIL ill_cmd3_resp got=%0d exp=0", resp); end
        step(NONE, 32'h80, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (resp !== 4'd0) begin failures++; $display("FAIL ill_none_resp got=%0d exp=0", resp); end
        step(LD, 32'h80, 64'd0);
        checks++; if (resp !== 4'd1) begin failures++; $display("FAIL ill_load_resp got=%0d exp=1", resp); end
        repeat (LAT) step(NONE, 32'd0, 64'd0);
        checks++; if (rtag !== 4'd1) begin failures++; $display("FAIL ill_tag got=%0d exp=1", rtag); end
        checks++; if (rdata !== 64'hC0C0_C0C0_C0C0_C0C0) begin failures++; $display("FAIL ill_data got=%h exp=c0c0c0c0c0c0c0c0", rdata); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] et;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(LD, 32'(i * 8), 64'd0);
            checks++; if (resp !== 4'(i)) begin failures++; $display("FAIL mid_pre_resp i=%0d got=%0d exp=%0d", i, resp, i); end
        end
        step(NONE, 32'd0, 64'd0);
        @(negedge clock);
        reset = 1'b0; cmd = LD;
        #1;
        checks++; if (resp !== 4'd0) begin failures++; $display("FAIL mid_rst_resp got=%0d exp=0", resp); end
        checks++; if (rtag !== 4'd0) begin failures++; $display("FAIL mid_rst_tag got=%0d exp=0", rtag); end
        @(negedge clock);
        cmd = NONE; reset = 1'b1; cyc = 0;
        step(LD, 32'h8, 64'd0);
        checks++; if (resp !== 4'd1) begin failures++; $display("FAIL mid_post_resp got=%0d exp=1", resp); end
        for (int c = 2; c <= LAT + 5; c++) begin
            step(NONE, 32'd0, 64'd0);
            et = (c == LAT + 1) ? 4'd1 : 4'd0;
            checks++; if (rtag !== et) begin failures++; $display("FAIL mid_tag cyc=%0d got=%0d exp=%0d", c, rtag, et); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_alias();
        test_race(1'b1);
        test_race(1'b0);
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
